bcd2bin: RTL

Iterative 4-digit packed-BCD to 10-bit binary converter; the inverse of the pipelined binary-to-BCD chain in bin2BCD. Accepts one BCD word over a valid/ready handshake and processes one digit per cycle, most significant first, as acc = acc*10 + digit. It presents the binary result with valid/ready backpressure. Sits between decimal front-panel/keypad logic and binary datapath consumers.

---
 rtl/bcd2bin.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bcd2bin.sv
// Iterative 4-digit packed-BCD to 10-bit binary converter, one digit per cycle, MSD first.
// Optional macro BCD2BIN_ERR_CHK_EN adds bad-digit / >1023 range flagging on bin_err.
module bcd2bin (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic        bcd_vld,
    output logic        bcd_rdy,
    output logic [9:0]  bin_out,
    output logic        bin_err,
    output logic        bin_vld,
    input  logic        bin_rdy,
    output logic [1:0]  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // bcd_rdy depends only on state, never on bcd_vld; bin_vld/bin_out/bin_err stay
    // stable until the edge that samples bin_rdy=1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] sh;
    logic [14:0] acc;
    logic [14:0] acc_nxt;
    logic [1:0]  dcnt;
    logic [3:0]  digit;
    logic        load;
    logic        step;
    logic        last;
    logic        rel;

    assign state_dbg = state;
    assign digit     = sh[15:12];
    // acc*10 + d; 15 bits covers the worst case 15*1111 without wrapping
    assign acc_nxt   = (acc << 3) + (acc << 1) + {11'd0, digit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bcd_rdy   = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        rel       = 1'b0;
        case (state)
            IDLE: begin
                bcd_rdy = 1'b1;
                if (bcd_vld) begin
                    load      = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                if (dcnt == 2'd0) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bin_rdy) begin
                    rel       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= 16'd0;
            acc     <= 15'd0;
            dcnt    <= 2'd0;
            bin_out <= 10'd0;
            bin_vld <= 1'b0;
        end else if (load) begin
            sh   <= bcd_in;
            acc  <= 15'd0;
            dcnt <= 2'd3;
        end else if (step) begin
            acc  <= acc_nxt;
            sh   <= {sh[11:0], 4'h0};
            dcnt <= dcnt - 2'd1;
            if (last) begin
                bin_out <= acc_nxt[9:0];
                bin_vld <= 1'b1;
            end
        end else if (rel) begin
            bin_vld <= 1'b0;
        end
    end

`ifdef BCD2BIN_ERR_CHK_EN
    logic err;
    logic digit_bad;
    logic range_bad;

    assign digit_bad = (digit > 4'd9);
    assign range_bad = (acc_nxt > 15'd1023);

    // err is sticky across the four digits of one word; the range test uses the final sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            bin_err <= 1'b0;
        end else if (load) begin
            err <= 1'b0;
        end else if (step) begin
            err <= err | digit_bad;
            if (last) begin
                bin_err <= err | digit_bad | range_bad;
            end
        end
    end
`else
    assign bin_err = 1'b0;
`endif

endmodule
